// File: rtl/div_ratio_detector.sv
// Measures the rising-to-rising period of a divided clock in clk cycles, decodes
// power-of-two divide ratios, and tracks lock on consecutive equal measurements.
module div_ratio_detector #(
    parameter int CNT_W  = 6,
    parameter int LOCK_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [2:0]       ratio,
    output logic             meas_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout
);

    localparam int               MC_W     = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] TMAX     = {CNT_W{1'b1}};
    localparam logic [MC_W-1:0]  LOCK_CNT = MC_W'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKING = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    logic             s1_r;
    logic             s2_r;
    logic             s3_r;
    logic             rise_s;
    logic [CNT_W-1:0] cnt_r;
    state_t           state_r;
    logic [MC_W-1:0]  match_r;
    logic [MC_W-1:0]  match_next_s;
    logic             same_s;
    logic             timeout_s;
    logic [2:0]       ratio_s;

    // Only exact powers of two from /2 to /32 get a code; everything else is 0.
    function automatic logic [2:0] ratio_of(input logic [CNT_W-1:0] n);
        case (32'(n))
            32'd2:   return 3'd1;
            32'd4:   return 3'd2;
            32'd8:   return 3'd3;
            32'd16:  return 3'd4;
            32'd32:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    assign rise_s  = s2_r & ~s3_r;
    assign same_s  = (cnt_r == period);
    assign ratio_s = ratio_of(cnt_r);

    // Next match count and timeout condition for the FSM.
    always_comb begin
        match_next_s = MC_W'(1'b1);
        timeout_s    = 1'b0;
        if ((state_r == LOCKING) && same_s) begin
            match_next_s = match_r + MC_W'(1'b1);
        end else begin
            match_next_s = MC_W'(1'b1);
        end
        if ((state_r != IDLE) && !rise_s && (cnt_r == TMAX)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Synchronizer with history flop, plus the saturating period counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r  <= 1'b0;
            s2_r  <= 1'b0;
            s3_r  <= 1'b0;
            cnt_r <= '0;
        end else begin
            s1_r <= div_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
            if (rise_s) begin
                cnt_r <= CNT_W'(1'b1);
            end else if (cnt_r != TMAX) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Measurement/lock FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            match_r    <= '0;
            period     <= '0;
            ratio      <= 3'd0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;
            timeout    <= 1'b0;
            if (timeout_s) begin
                // Period is deliberately held so the last good value stays visible.
                timeout <= 1'b1;
                state_r <= IDLE;
                locked  <= 1'b0;
                ratio   <= 3'd0;
                match_r <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (rise_s) begin
                            state_r <= ARMED;
                        end
                    end
                    ARMED, LOCKING: begin
                        if (rise_s) begin
                            period     <= cnt_r;
                            ratio      <= ratio_s;
                            meas_valid <= 1'b1;
                            match_r    <= match_next_s;
                            if (match_next_s >= LOCK_CNT) begin
                                state_r <= LOCKED;
                                locked  <= 1'b1;
                            end else begin
                                state_r <= LOCKING;
                            end
                        end
                    end
                    LOCKED: begin
                        if (rise_s) begin
                            period     <= cnt_r;
                            ratio      <= ratio_s;
                            meas_valid <= 1'b1;
                            if (!same_s) begin
                                mismatch <= 1'b1;
                                locked   <= 1'b0;
                                match_r  <= MC_W'(1'b1);
                                state_r  <= LOCKING;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        locked  <= 1'b0;
                        match_r <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_ratio_detector.sv
// Bench for div_ratio_detector: edge-timing reference model checked every cycle,
// a table of divider scenarios, hand-written corner sequences and random gaps.
module tb_div_ratio_detector;

    logic       clk;
    logic       rst;
    logic       div_in;
    logic [5:0] period;
    logic [2:0] ratio;
    logic       meas_valid;
    logic       locked;
    logic       mismatch;
    logic       timeout;

    div_ratio_detector #(.CNT_W(6), .LOCK_N(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_in     (div_in),
        .period     (period),
        .ratio      (ratio),
        .meas_valid (meas_valid),
        .locked     (locked),
        .mismatch   (mismatch),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // reference model state: works on rise times, not on counter/FSM encoding
    int e       = 0;
    bit m_prev  = 1'b0;
    bit m_dly[$];
    bit m_active = 1'b0;
    int t_last  = 0;
    int m_run   = 0;
    int x_period = 0;
    int x_ratio  = 0;
    bit x_mv = 1'b0, x_locked = 1'b0, x_mm = 1'b0, x_to = 1'b0;

    // observations for the hand-written sequences
    int mv_cnt = 0, mm_cnt = 0, to_cnt = 0;
    int last_mv_e = 0, to_e = 0, lock_at_mv = -1;

    function automatic int m_ratio(input int n);
        for (int k = 1; k <= 5; k++) begin
            if (n == (1 << k)) return k;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_prev = 1'b0;
        m_dly.delete();
        m_dly.push_back(1'b0);
        m_dly.push_back(1'b0);
        m_active = 1'b0;
        m_run = 0;
        x_period = 0; x_ratio = 0;
        x_mv = 1'b0; x_locked = 1'b0; x_mm = 1'b0; x_to = 1'b0;
    endtask

    task automatic model_edge();
        bit rin;
        bit rnow;
        int n;
        e = e + 1;
        rin = div_in && !m_prev;
        m_prev = div_in;
        rnow = m_dly.pop_front();
        m_dly.push_back(rin);
        x_mv = 1'b0; x_mm = 1'b0; x_to = 1'b0;
        if (rnow) begin
            if (m_active) begin
                n = e - t_last;
                x_mv = 1'b1;
                if (x_locked) begin
                    if (n != x_period) begin
                        x_mm = 1'b1;
                        x_locked = 1'b0;
                        m_run = 1;
                    end
                end else begin
                    m_run = (m_run > 0 && n == x_period) ? m_run + 1 : 1;
                    if (m_run >= 3) x_locked = 1'b1;
                end
                x_period = n;
                x_ratio = m_ratio(n);
            end
            m_active = 1'b1;
            t_last = e;
        end else if (m_active && (e - t_last) == 63) begin
            x_to = 1'b1;
            m_active = 1'b0;
            x_locked = 1'b0;
            x_ratio = 0;
            m_run = 0;
        end
    endtask

    task automatic check_cycle(input string name);
        n_vec++;
        if (int'(period) != x_period || int'(ratio) != x_ratio || meas_valid !== x_mv ||
            locked !== x_locked || mismatch !== x_mm || timeout !== x_to) begin
            n_fail++;
            $display("FAIL %s e=%0d: got p=%0d r=%0d mv=%0b lk=%0b mm=%0b to=%0b, want p=%0d r=%0d mv=%0b lk=%0b mm=%0b to=%0b",
                     name, e, period, ratio, meas_valid, locked, mismatch, timeout,
                     x_period, x_ratio, x_mv, x_locked, x_mm, x_to);
        end
    endtask

    task automatic expect_eq(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic d);
        div_in = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle("cycle");
        if (meas_valid) begin
            mv_cnt++;
            last_mv_e = e;
        end
        if (mismatch) mm_cnt++;
        if (timeout) begin
            to_cnt++;
            to_e = e;
        end
        if (locked && lock_at_mv < 0) lock_at_mv = mv_cnt;
    endtask

    task automatic pulse(input int g, input int h);
        for (int i = 0; i < g; i++) tick(i < h);
    endtask

    // asserted between clock edges: outputs must clear without waiting for clk
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_cycle("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int div;
        int npulse;
        int exp_period;
        int exp_ratio;
        int exp_locked;
    } row_t;

    row_t rows[9];

    initial begin
        int g;
        int reps;
        rst = 1'b1;
        div_in = 1'b0;
        model_reset();

        rows[0] = '{2, 5, 2, 1, 1};
        rows[1] = '{4, 4, 4, 2, 1};
        rows[2] = '{8, 4, 8, 3, 1};
        rows[3] = '{16, 3, 16, 4, 0};
        rows[4] = '{32, 4, 32, 5, 1};
        rows[5] = '{12, 4, 12, 0, 1};
        rows[6] = '{3, 5, 3, 0, 1};
        rows[7] = '{63, 3, 63, 0, 0};
        rows[8] = '{64, 4, 0, 0, 0};

        #2;
        do_reset();

        foreach (rows[i]) begin
            do_reset();
            for (int p = 0; p < rows[i].npulse; p++)
                pulse(rows[i].div, (rows[i].div / 2 > 0) ? rows[i].div / 2 : 1);
            repeat (4) tick(1'b0);
            expect_eq($sformatf("row%0d_period", i), int'(period), rows[i].exp_period);
            expect_eq($sformatf("row%0d_ratio", i), int'(ratio), rows[i].exp_ratio);
            expect_eq($sformatf("row%0d_locked", i), int'(locked), rows[i].exp_locked);
        end

        // locked at /8, then the divider changes to /16
        do_reset();
        mm_cnt = 0;
        repeat (5) pulse(8, 4);
        repeat (4) pulse(16, 8);
        repeat (3) tick(1'b0);
        expect_eq("switch_mismatch_pulses", mm_cnt, 1);
        expect_eq("switch_relocked", int'(locked), 1);
        expect_eq("switch_period", int'(period), 16);

        // locked at /4, then div_in stops
        do_reset();
        to_cnt = 0;
        repeat (5) pulse(4, 2);
        repeat (70) tick(1'b0);
        expect_eq("timeout_pulses", to_cnt, 1);
        expect_eq("timeout_delay", to_e - last_mv_e, 63);
        expect_eq("timeout_period_held", int'(period), 4);
        expect_eq("timeout_ratio", int'(ratio), 0);
        expect_eq("timeout_locked", int'(locked), 0);

        // reset while LOCKING at /8 with div_in high through reset
        do_reset();
        repeat (3) pulse(8, 4);
        tick(1'b1);
        do_reset();
        mv_cnt = 0;
        lock_at_mv = -1;
        repeat (6) pulse(8, 4);
        repeat (3) tick(1'b0);
        expect_eq("relock_after_reset_meas", lock_at_mv, 3);

        // random edge spacings, including gaps around the timeout limit
        do_reset();
        for (int s = 0; s < 120; s++) begin
            if ($urandom_range(0, 9) == 0) g = $urandom_range(60, 66);
            else g = $urandom_range(2, 34);
            reps = $urandom_range(1, 5);
            for (int r = 0; r < reps; r++) pulse(g, $urandom_range(1, g - 1));
            if ($urandom_range(0, 19) == 0) do_reset();
        end
        repeat (70) tick(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
